// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue controller.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } div_state_e;

  localparam logic [31:0] DIV_INT_MIN   = 32'h8000_0000;
  localparam logic [31:0] DIV_MINUS_ONE = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  localparam int unsigned SETTLE_W = 4;

endpackage

// File: rtl/div_special_detect.sv
// Classifies a divide request as zero-divide, signed overflow or normal.
module div_special_detect
  import div_pkg::*;
(
  input  logic [31:0] dividend_i,
  input  logic [31:0] divider_i,
  input  logic        signed_i,
  output logic        is_zero_o,
  output logic        is_ovf_o
);

  always_comb begin
    is_zero_o = (divider_i == '0);
    // Only INT_MIN / -1 in signed mode overflows; zero divisor takes priority.
    is_ovf_o  = !is_zero_o && signed_i &&
                (dividend_i == DIV_INT_MIN) && (divider_i == DIV_MINUS_ONE);
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issues one request at a time to an external combinational divider, waits
// for it to settle, and holds the captured result until the consumer accepts.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_dividend,
  input  logic [31:0] req_divider,
  input  logic        req_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divider,
  output logic        div_s,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_quotient,
  output logic [31:0] rsp_remainder,
  output logic        rsp_error,
  output logic        rsp_overflow
);

  localparam logic [SETTLE_W-1:0] CNT_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  div_state_e          state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [31:0]         dvd_q, dvd_d;
  logic [31:0]         dvr_q, dvr_d;
  logic                s_q, s_d;
  logic [31:0]         quot_q, quot_d;
  logic [31:0]         rem_q, rem_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;

  logic is_zero;
  logic is_ovf;

  div_special_detect u_detect (
    .dividend_i (req_dividend),
    .divider_i  (req_divider),
    .signed_i   (req_signed),
    .is_zero_o  (is_zero),
    .is_ovf_o   (is_ovf)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvr_d   = dvr_q;
    s_d     = s_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          dvd_d = req_dividend;
          dvr_d = req_divider;
          s_d   = req_signed;
          // Special cases are answered directly; the divider output is unused.
          if (is_zero) begin
            quot_d  = DIV_ZERO_QUOT;
            rem_d   = req_dividend;
            err_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = ST_RESP;
          end else if (is_ovf) begin
            quot_d  = DIV_INT_MIN;
            rem_d   = '0;
            err_d   = 1'b0;
            ovf_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          quot_d  = div_quotient;
          rem_d   = div_remainder;
          err_d   = div_error;
          ovf_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvr_q   <= '0;
      s_q     <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvr_q   <= dvr_d;
      s_q     <= s_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign rsp_valid     = (state_q == ST_RESP);
  assign div_dividend  = dvd_q;
  assign div_divider   = dvr_q;
  assign div_s         = s_q;
  assign rsp_quotient  = quot_q;
  assign rsp_remainder = rem_q;
  assign rsp_error     = err_q;
  assign rsp_overflow  = ovf_q;

endmodule
